fp_div_seq: RTL and testbench

- Iterative IEEE-754 single-precision divider; the inverse of the team's combinational multiplier.
- Computes `result = dividend / divisor` with a radix-2 restoring quotient loop, then rounds to nearest-even.
- Exchanges operands and results over valid/ready handshakes.
- Sits beside the multiplier in the single-precision FPU datapath and shares its overflow/underflow flag semantics.

---
 rtl/fp_div_seq.sv | 190 +++++++++++++++++++
 tb/tb_fp_div_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring quotient loop, round-to-nearest-even, FTZ.
// Optional FPU_DIV_EARLY_OUT_EN: special-case operands skip the quotient loop and complete in one cycle.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);
    localparam int unsigned M_W   = 24;
    localparam int unsigned Q_W   = 26;
    localparam int unsigned T_W   = Q_W + 1;
    localparam int unsigned E_W   = 10;
    localparam int unsigned ITERS = 26;
    localparam int unsigned CNT_W = 5;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
    state_t state;

    logic                  sign_q;
    logic                  sp_hit_q;
    logic                  sp_inv_q;
    logic                  sp_dbz_q;
    logic [31:0]           sp_res_q;
    logic [M_W-1:0]        dvs_q;
    logic [Q_W-1:0]        rem_q;
    logic [Q_W-1:0]        q_q;
    logic signed [E_W-1:0] exp_q;
    logic [CNT_W-1:0]      cnt_q;

    assign in_ready = (state == IDLE) && !rst;

    // Operand classification and special-case result, priority NaN/invalid > div-by-zero > inf > zero
    logic [7:0]  e1, e2;
    logic [22:0] m1, m2;
    logic        sign_in, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        sp_hit, sp_inv, sp_dbz;
    logic [31:0] sp_res;
    always_comb begin
        e1      = data1[30:23];
        e2      = data2[30:23];
        m1      = data1[22:0];
        m2      = data2[22:0];
        sign_in = data1[31] ^ data2[31];
        a_zero  = (e1 == 8'd0);
        b_zero  = (e2 == 8'd0);
        a_inf   = (e1 == 8'hFF) && (m1 == 23'd0);
        b_inf   = (e2 == 8'hFF) && (m2 == 23'd0);
        a_nan   = (e1 == 8'hFF) && (m1 != 23'd0);
        b_nan   = (e2 == 8'hFF) && (m2 != 23'd0);
        sp_hit  = 1'b1;
        sp_inv  = 1'b0;
        sp_dbz  = 1'b0;
        sp_res  = {sign_in, 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (b_zero && !a_inf) begin
            sp_res = {sign_in, 8'hFF, 23'd0};
            sp_dbz = 1'b1;
        end else if (a_inf) begin
            sp_res = {sign_in, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            sp_res = {sign_in, 31'd0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // One restoring step: compare before shifting, so the first step yields the 2^0 quotient bit
    logic [T_W-1:0] trial;
    logic           no_borrow;
    logic [Q_W-1:0] rem_next;
    always_comb begin
        trial     = {1'b0, rem_q} - T_W'(dvs_q);
        no_borrow = ~trial[Q_W];
        rem_next  = no_borrow ? trial[Q_W-1:0] : rem_q;
    end

    // Normalise, round to nearest-even, then range-check the final exponent
    logic [22:0]           frac;
    logic                  guard, sticky, inc;
    logic [23:0]           frac_sum;
    logic signed [E_W-1:0] e_n, e_r;
    logic [31:0]           rnd_res;
    logic                  rnd_ovf, rnd_unf;
    always_comb begin
        if (q_q[Q_W-1]) begin
            frac   = q_q[Q_W-2:2];
            guard  = q_q[1];
            sticky = q_q[0] | (|rem_q);
            e_n    = exp_q;
        end else begin
            frac   = q_q[Q_W-3:1];
            guard  = q_q[0];
            sticky = |rem_q;
            e_n    = exp_q - E_W'(1);
        end
        inc      = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + 24'(inc);
        e_r      = e_n + E_W'(frac_sum[23]);
        rnd_ovf  = 1'b0;
        rnd_unf  = 1'b0;
        if (e_r >= 10'sd255) begin
            rnd_res = {sign_q, 8'hFF, 23'd0};
            rnd_ovf = 1'b1;
        end else if (e_r <= 10'sd0) begin
            rnd_res = {sign_q, 31'd0};
            rnd_unf = 1'b1;
        end else begin
            rnd_res = {sign_q, e_r[7:0], frac_sum[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            result      <= 32'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= sign_in;
                        sp_hit_q <= sp_hit;
                        sp_inv_q <= sp_inv;
                        sp_dbz_q <= sp_dbz;
                        sp_res_q <= sp_res;
                        rem_q    <= Q_W'({1'b1, m1});
                        dvs_q    <= {1'b1, m2};
                        q_q      <= '0;
                        exp_q    <= E_W'(e1) - E_W'(e2) + E_W'(127);
                        cnt_q    <= '0;
`ifdef FPU_DIV_EARLY_OUT_EN
                        if (sp_hit) begin
                            result      <= sp_res;
                            overflow    <= 1'b0;
                            underflow   <= 1'b0;
                            div_by_zero <= sp_dbz;
                            invalid     <= sp_inv;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_q <= rem_next << 1;
                    q_q   <= {q_q[Q_W-2:0], no_borrow};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) state <= ROUND;
                end
                ROUND: begin
                    result      <= sp_hit_q ? sp_res_q : rnd_res;
                    overflow    <= !sp_hit_q && rnd_ovf;
                    underflow   <= !sp_hit_q && rnd_unf;
                    div_by_zero <= sp_hit_q && sp_dbz_q;
                    invalid     <= sp_hit_q && sp_inv_q;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed and random divisions against an exact integer-ratio reference model.
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FPU_DIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    fp_div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data1      (data1),
        .data2      (data2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .underflow  (underflow),
        .div_by_zero(div_by_zero),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient with a 24-bit significand, rounding decided from the true remainder
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f, output bit sp);
        int ea, eb, e;
        bit s, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
        longint unsigned ma, mb, num, qt, rm;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 23'd0);
        b_inf  = (eb == 255) && (b[22:0] == 23'd0);
        a_nan  = (ea == 255) && (a[22:0] != 23'd0);
        b_nan  = (eb == 255) && (b[22:0] != 23'd0);
        f  = 4'b0000;
        sp = 1'b1;
        r  = 32'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            r = 32'h7FC0_0000;
            f = 4'b0001;
        end else if (a_inf) begin
            r = {s, 8'hFF, 23'd0};
        end else if (b_zero) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b0010;
        end else if (a_zero || b_inf) begin
            r = {s, 31'd0};
        end else begin
            sp = 1'b0;
            ma = 64'({1'b1, a[22:0]});
            mb = 64'({1'b1, b[22:0]});
            e  = ea - eb + 127;
            if (ma >= mb) num = ma << 23;
            else begin
                num = ma << 24;
                e   = e - 1;
            end
            qt = num / mb;
            rm = num % mb;
            if ((2 * rm > mb) || ((2 * rm == mb) && qt[0])) qt++;
            if (qt == (64'd1 << 24)) begin
                qt = qt >> 1;
                e++;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b1000;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f = 4'b0100;
            end else begin
                r = {s, 8'(e), 23'(qt)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        int unsigned cls;
        logic [7:0]  e;
        logic [22:0] m;
        cls = $urandom_range(0, 11);
        m   = 23'($urandom);
        case (cls)
            0:       e = 8'd0;
            1:       begin e = 8'hFF; m = 23'd0; end
            2:       begin e = 8'hFF; m = m | 23'd1; end
            3, 4:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, m};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] er;
        logic [3:0]  ef;
        bit          sp;
        int          lat;
        int          exp_lat;
        ref_div(a, b, er, ef, sp);
        exp_lat = (sp && EARLY_OUT) ? 1 : 28;
        @(negedge clk);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        data1    = a;
        data2    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".result"}, result, er);
        check_eq({tag, ".flags"}, 32'({overflow, underflow, div_by_zero, invalid}), 32'(ef));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dir_a [12] = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                                32'h0000_0000, 32'hFF80_0000, 32'h7F7F_FFFF, 32'h0080_0000,
                                32'h7FC0_1234, 32'h7F80_0000, 32'hC040_0000, 32'h7F80_0000};
    logic [31:0] dir_b [12] = '{32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0000_0000,
                                32'h0000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4000_0000,
                                32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h8000_0000};

    initial begin
        int  lat;
        bit  seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data1     = 32'd0;
        data2     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.out_valid", 32'(out_valid), 32'd0);
        check_eq("reset.result", result, 32'd0);
        check_eq("reset.flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'd0);
        check_eq("reset.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1 check_eq("reset_release.in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++)
            run_op(dir_a[i], dir_b[i], $sformatf("dir%0d", i));

        // Backpressure: result held while the consumer stalls, new operands ignored
        out_ready = 1'b0;
        @(negedge clk);
        data1    = 32'h40C0_0000;
        data2    = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        check_eq("bp.latency", 32'(lat), 32'd28);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
            check_eq($sformatf("bp%0d.result", k), result, 32'h4040_0000);
            check_eq($sformatf("bp%0d.flags", k), 32'({overflow, underflow, div_by_zero, invalid}), 32'd0);
            check_eq($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
            if (k == 1) begin
                data1    = 32'h3F80_0000;
                data2    = 32'h4040_0000;
                in_valid = 1'b1;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_release.in_ready", 32'(in_ready), 32'd1);
        check_eq("bp_release.out_valid", 32'(out_valid), 32'd0);
        run_op(32'h3F80_0000, 32'h3F80_0000, "after_bp");

        // Reset in the middle of CALC aborts the operation
        @(negedge clk);
        data1    = 32'h40C0_0000;
        data2    = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort.out_valid", 32'(out_valid), 32'd0);
        check_eq("abort.result", result, 32'd0);
        check_eq("abort.flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'd0);
        check_eq("abort.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("abort_release.in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort.no_output", 32'(seen), 32'd0);
        run_op(32'h40C0_0000, 32'h4000_0000, "after_abort");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = rand_operand();
            b = rand_operand();
            run_op(a, b, $sformatf("rnd%0d_%h_%h", i, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
